// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding req/ack fetch and next-PC selection.
// Optional fetch watchdog is compiled in when FETCH_TIMEOUT_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        Muxif,
    input  logic        jr_sel,
    input  logic [31:0] jr_target,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  Opcode,
    output logic [5:0]  Function,
    output logic [31:0] pc_out,
    output logic        fetch_err
);
    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_WAIT  = 2'b01,
        ST_VALID = 2'b10
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        valid_r;
    logic [5:0]  opcode_r;
    logic [5:0]  function_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] next_pc_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] to_cnt_r;
    logic             fetch_err_r;

    assign fetch_err = fetch_err_r;
`else
    // The watchdog is absent; TIMEOUT stays referenced so both builds share one parameter list.
    assign fetch_err = 1'b0 & (TIMEOUT != 0);
`endif

    // Request is a decode of the FETCH state, suppressed while reset is held.
    assign imem_req    = (state_r == ST_FETCH) && !reset;
    assign imem_addr   = pc_r;
    assign pc_out      = pc_r;
    assign instr       = instr_r;
    assign instr_valid = valid_r;
    assign Opcode      = opcode_r;
    assign Function    = function_r;

    // Next-PC selection: sequential, j-type region jump, or word-aligned register jump.
    always_comb begin
        pc_plus4_s = pc_r + 32'd4;
        next_pc_s  = pc_plus4_s;
        if (!Muxif) begin
            next_pc_s = pc_plus4_s;
        end else if (jr_sel) begin
            next_pc_s = jr_target & 32'hFFFF_FFFC;
        end else begin
            next_pc_s = {pc_plus4_s[31:28], instr_r[25:0], 2'b00};
        end
    end

    // Fetch FSM with PC, instruction and decoded-field registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            instr_r    <= 32'h0000_0000;
            valid_r    <= 1'b0;
            opcode_r   <= 6'd0;
            function_r <= 6'd0;
`ifdef FETCH_TIMEOUT_EN
            to_cnt_r    <= '0;
            fetch_err_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_FETCH: begin
                    state_r <= ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
                    to_cnt_r <= '0;
`endif
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        instr_r    <= imem_rdata;
                        opcode_r   <= imem_rdata[31:26];
                        function_r <= imem_rdata[5:0];
                        valid_r    <= 1'b1;
                        state_r    <= ST_VALID;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (to_cnt_r == TO_LAST) begin
                        // No response: substitute a NOP so the pipeline keeps moving.
                        instr_r     <= 32'h0000_0000;
                        opcode_r    <= 6'd0;
                        function_r  <= 6'd0;
                        valid_r     <= 1'b1;
                        fetch_err_r <= 1'b1;
                        state_r     <= ST_VALID;
                    end else begin
                        to_cnt_r <= to_cnt_r + CNT_W'(1);
                    end
`else
                    else begin
                        state_r <= ST_WAIT;
                    end
`endif
                end
                ST_VALID: begin
                    if (!stall) begin
                        pc_r       <= next_pc_s;
                        valid_r    <= 1'b0;
                        opcode_r   <= 6'd0;
                        function_r <= 6'd0;
                        state_r    <= ST_FETCH;
                    end else begin
                        state_r <= ST_VALID;
                    end
                end
                default: begin
                    state_r <= ST_FETCH;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized runs against a PC model.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC_A = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_B = 32'hFFFF_FFFC;
    localparam int          TIMEOUT    = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        Muxif;
    logic        jr_sel;
    logic [31:0] jr_target;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  Opcode;
    logic [5:0]  Function;
    logic [31:0] pc_out;
    logic        fetch_err;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic        w_valid;
    logic [5:0]  w_opcode;
    logic [5:0]  w_function;
    logic [31:0] w_pc;
    logic        w_err;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RESET_PC_A), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .Muxif(Muxif),
        .jr_sel(jr_sel), .jr_target(jr_target), .instr(instr), .instr_valid(instr_valid),
        .Opcode(Opcode), .Function(Function), .pc_out(pc_out), .fetch_err(fetch_err)
    );

    instr_fetch_unit #(.RESET_PC(RESET_PC_B), .TIMEOUT(TIMEOUT)) dut_wrap (
        .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .Muxif(Muxif),
        .jr_sel(jr_sel), .jr_target(jr_target), .instr(w_instr), .instr_valid(w_valid),
        .Opcode(w_opcode), .Function(w_function), .pc_out(w_pc), .fetch_err(w_err)
    );

    // Reference next-PC written with plain arithmetic on whole words.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                               input logic mux, input logic jr,
                                               input logic [31:0] tgt);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (!mux) return seq;
        if (jr) return tgt - (tgt % 32'd4);
        return (seq / 32'h1000_0000) * 32'h1000_0000 + (ins % 32'h0400_0000) * 32'd4;
    endfunction

    // Called during the request cycle; answers after lat cycles and returns in VALID.
    task automatic serve(input int lat, input logic [31:0] data);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            imem_ack   = (i == lat);
            imem_rdata = (i == lat) ? data : $urandom;
        end
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        m_instr    = data;
    endtask

    // Leaves VALID with the given redirect inputs and advances the model PC.
    task automatic release_valid(input logic mux, input logic jr, input logic [31:0] tgt);
        Muxif     = mux;
        jr_sel    = jr;
        jr_target = tgt;
        stall     = 1'b0;
        m_pc      = model_next(m_pc, m_instr, mux, jr, tgt);
        @(negedge clk);
        stall     = 1'b1;
        Muxif     = 1'b0;
        jr_sel    = 1'b0;
        jr_target = $urandom;
    endtask

    task automatic test_reset;
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b1;
        Muxif = 1'b0; jr_sel = 1'b0; jr_target = 32'h0;
        repeat (3) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req actual=%0b expected=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%0b expected=0", instr_valid); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr actual=%08h expected=00000000", instr); end
        checks++; if ({Opcode, Function} !== 12'h0) begin failures++; $display("FAIL reset_fields actual=%03h expected=000", {Opcode, Function}); end
        checks++; if (pc_out !== RESET_PC_A) begin failures++; $display("FAIL reset_pc actual=%08h expected=%08h", pc_out, RESET_PC_A); end
        checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_err actual=%0b expected=0", fetch_err); end
        checks++; if (w_pc !== RESET_PC_B) begin failures++; $display("FAIL reset_pc_wrap actual=%08h expected=%08h", w_pc, RESET_PC_B); end
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req actual=%0b expected=1", imem_req); end
        checks++; if (imem_addr !== RESET_PC_A) begin failures++; $display("FAIL first_addr actual=%08h expected=%08h", imem_addr, RESET_PC_A); end
        checks++; if (w_addr !== RESET_PC_B) begin failures++; $display("FAIL first_addr_wrap actual=%08h expected=%08h", w_addr, RESET_PC_B); end
        m_pc = RESET_PC_A;
    endtask

    task automatic test_first_fetch;
        serve(1, 32'h0109_5020);
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL ff_valid actual=%0b expected=1", instr_valid); end
        checks++; if (instr !== 32'h0109_5020) begin failures++; $display("FAIL ff_instr actual=%08h expected=01095020", instr); end
        checks++; if (Opcode !== 6'h00) begin failures++; $display("FAIL ff_opcode actual=%02h expected=00", Opcode); end
        checks++; if (Function !== 6'h20) begin failures++; $display("FAIL ff_function actual=%02h expected=20", Function); end
        checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL ff_pc actual=%08h expected=00000000", pc_out); end
        release_valid(1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL ff_next_addr actual=%08h expected=00000004", imem_addr); end
        checks++; if (w_addr !== 32'h0) begin failures++; $display("FAIL wrap_next_addr actual=%08h expected=00000000", w_addr); end
    endtask

    task automatic test_sequential;
        logic [31:0] d;
        for (int k = 0; k < 3; k++) begin
            checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL seq_req actual=%0b expected=1", imem_req); end
            checks++; if (imem_addr !== m_pc) begin failures++; $display("FAIL seq_addr actual=%08h expected=%08h", imem_addr, m_pc); end
            checks++; if ({instr_valid, Opcode, Function} !== 13'h0) begin failures++; $display("FAIL seq_bubble actual=%04h expected=0000", {instr_valid, Opcode, Function}); end
            d = $urandom | 32'h8000_0000;
            serve(3, d);
            checks++; if (instr !== d || instr_valid !== 1'b1) begin failures++; $display("FAIL seq_instr actual=%08h/%0b expected=%08h/1", instr, instr_valid, d); end
            release_valid(1'b0, 1'b0, 32'h0);
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== m_pc) begin failures++; $display("FAIL seq_last_req actual=%0b/%08h expected=1/%08h", imem_req, imem_addr, m_pc); end
    endtask

    task automatic test_jump;
        serve(1, $urandom);
        release_valid(1'b1, 1'b1, 32'h0040_0000);
        checks++; if (imem_addr !== 32'h0040_0000) begin failures++; $display("FAIL jr_setup_addr actual=%08h expected=00400000", imem_addr); end
        serve(2, 32'h0800_0010);
        checks++; if (Opcode !== 6'h02) begin failures++; $display("FAIL j_opcode actual=%02h expected=02", Opcode); end
        release_valid(1'b1, 1'b0, $urandom);
        checks++; if (imem_addr !== 32'h0000_0040) begin failures++; $display("FAIL j_addr actual=%08h expected=00000040", imem_addr); end
        serve(1, $urandom);
        release_valid(1'b1, 1'b1, 32'h0000_1236);
        checks++; if (imem_addr !== 32'h0000_1234) begin failures++; $display("FAIL jr_addr actual=%08h expected=00001234", imem_addr); end
        serve(1, $urandom);
        release_valid(1'b1, 1'b1, 32'hFFFF_FFFF);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL jr_top_addr actual=%08h expected=fffffffc", imem_addr); end
        serve(1, $urandom);
        release_valid(1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h0000_0000) begin failures++; $display("FAIL wrap_addr actual=%08h expected=00000000", imem_addr); end
    endtask

    task automatic test_stall_late_ack;
        logic [31:0] d;
        logic [31:0] d2;
        d = $urandom;
        serve(2, d);
        Muxif = 1'b1; jr_sel = 1'b1; jr_target = 32'h0000_8000;
        for (int c = 0; c < 5; c++) begin
            imem_ack   = (c == 2);
            imem_rdata = ~d;
            @(negedge clk);
            checks++; if (instr !== d || pc_out !== m_pc || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
                failures++; $display("FAIL stall_hold actual=%08h/%08h/%0b/%0b expected=%08h/%08h/0/1", instr, pc_out, imem_req, instr_valid, d, m_pc);
            end
        end
        imem_ack = 1'b0;
        release_valid(1'b0, 1'b0, 32'h0000_8000);
        checks++; if (imem_req !== 1'b1 || imem_addr !== m_pc) begin failures++; $display("FAIL stall_release actual=%0b/%08h expected=1/%08h", imem_req, imem_addr, m_pc); end
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL fetch_ack_drop actual=%0b/%0b expected=0/0", instr_valid, imem_req); end
        d2 = $urandom;
        imem_ack = 1'b1; imem_rdata = d2;
        @(negedge clk);
        imem_ack = 1'b0; m_instr = d2;
        checks++; if (instr_valid !== 1'b1 || instr !== d2) begin failures++; $display("FAIL after_drop_instr actual=%0b/%08h expected=1/%08h", instr_valid, instr, d2); end
        release_valid(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] d;
        @(negedge clk);
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin failures++; $display("FAIL reset_vs_ack actual=%0b/%08h expected=0/00000000", instr_valid, instr); end
        reset = 1'b0; imem_rdata = 32'h1234_5678;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC_A) begin failures++; $display("FAIL restart_req actual=%0b/%08h expected=1/%08h", imem_req, imem_addr, RESET_PC_A); end
        m_pc = RESET_PC_A;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stray_ack actual=%0b expected=0", instr_valid); end
        d = $urandom;
        imem_ack = 1'b1; imem_rdata = d;
        @(negedge clk);
        imem_ack = 1'b0; m_instr = d;
        checks++; if (instr_valid !== 1'b1 || instr !== d || pc_out !== RESET_PC_A) begin failures++; $display("FAIL restart_instr actual=%0b/%08h/%08h expected=1/%08h/%08h", instr_valid, instr, pc_out, d, RESET_PC_A); end
        release_valid(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_random;
        logic [31:0] d;
        int          nst;
        for (int it = 0; it < 40; it++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== m_pc) begin failures++; $display("FAIL rnd_req it=%0d actual=%0b/%08h expected=1/%08h", it, imem_req, imem_addr, m_pc); end
            d = $urandom;
            serve($urandom_range(1, 4), d);
            checks++; if (instr_valid !== 1'b1 || instr !== d || pc_out !== m_pc) begin failures++; $display("FAIL rnd_instr it=%0d actual=%0b/%08h/%08h expected=1/%08h/%08h", it, instr_valid, instr, pc_out, d, m_pc); end
            checks++; if (Opcode !== d[31:26] || Function !== d[5:0]) begin failures++; $display("FAIL rnd_fields it=%0d actual=%02h/%02h expected=%02h/%02h", it, Opcode, Function, d[31:26], d[5:0]); end
            nst = $urandom_range(0, 3);
            for (int c = 0; c < nst; c++) begin
                Muxif = $urandom; jr_sel = $urandom; jr_target = $urandom;
                @(negedge clk);
                checks++; if (imem_req !== 1'b0 || instr !== d) begin failures++; $display("FAIL rnd_stall it=%0d actual=%0b/%08h expected=0/%08h", it, imem_req, instr, d); end
            end
            release_valid($urandom, $urandom, $urandom);
        end
    endtask

    task automatic test_timeout;
        int bad = 0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(negedge clk);
            if (instr_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL to_early actual=%0d expected=0", bad); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0 || {Opcode, Function} !== 12'h0) begin failures++; $display("FAIL to_nop actual=%0b/%08h expected=1/00000000", instr_valid, instr); end
        checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL to_err actual=%0b expected=1", fetch_err); end
        m_instr = 32'h0;
        release_valid(1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== m_pc || fetch_err !== 1'b1) begin failures++; $display("FAIL to_next actual=%08h/%0b expected=%08h/1", imem_addr, fetch_err, m_pc); end
`else
        repeat (40) begin
            @(negedge clk);
            if (instr_valid !== 1'b0 || fetch_err !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL wait_forever actual=%0d expected=0", bad); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0008;
        @(negedge clk);
        imem_ack = 1'b0; m_instr = 32'h0000_0008;
        checks++; if (instr_valid !== 1'b1 || fetch_err !== 1'b0) begin failures++; $display("FAIL long_wait_ack actual=%0b/%0b expected=1/0", instr_valid, fetch_err); end
        release_valid(1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== m_pc) begin failures++; $display("FAIL long_wait_next actual=%08h expected=%08h", imem_addr, m_pc); end
`endif
    endtask

    initial begin
        test_reset;
        test_first_fetch;
        test_sequential;
        test_jump;
        test_stall_late_ack;
        test_reset_mid_wait;
        test_random;
        test_timeout;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
